hazard_ctrl: RTL and testbench

//  Pipeline hazard/stall controller for the 5-stage RISC-V core, beside Forwarding_Unit in ID/EX.

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/load_use_detect.sv | 17 +
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/stall controller: FSM states,
// default multiplier latency and the bundle of pipeline control strobes.
package hazard_pkg;

    localparam int MUL_LAT_DEF = 4;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL      = 2'd1,
        MUL_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_bubble;
        logic ex_mem_stall;
        logic ex_mem_bubble;
        logic mul_start;
    } stall_t;

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load currently in EX.
module load_use_detect (
    input  logic [4:0] ID_rs1,
    input  logic [4:0] ID_rs2,
    input  logic       ID_use_rs1,
    input  logic       ID_use_rs2,
    input  logic       ID_EX_MemRead,
    input  logic [4:0] ID_EX_rd,
    output logic       load_use
);

    // x0 is hardwired to zero, so a load into it never creates a dependency
    assign load_use = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
                      ((ID_use_rs1 && (ID_rs1 == ID_EX_rd)) ||
                       (ID_use_rs2 && (ID_rs2 == ID_EX_rd)));

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: load-use stalls, multiplier occupancy in EX,
// D-cache freezes and taken-branch flushes, plus a saturating stall counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_is_mul,
    input  logic             dcache_stall,
    input  logic             branch_flush,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_bubble,
    output logic             ex_mem_stall,
    output logic             ex_mem_bubble,
    output logic             mul_start,
    output logic             mul_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int CW = $clog2(MUL_LAT + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    stall_t           st;
    logic             load_use;

    load_use_detect u_lud (
        .ID_rs1        (ID_rs1),
        .ID_rs2        (ID_rs2),
        .ID_use_rs1    (ID_use_rs1),
        .ID_use_rs2    (ID_use_rs2),
        .ID_EX_MemRead (ID_EX_MemRead),
        .ID_EX_rd      (ID_EX_rd),
        .load_use      (load_use)
    );

    always_comb begin
        st      = '0;
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;

        case (state_q)
            RUN: begin
                if (ID_EX_is_mul && !dcache_stall) begin
                    st.mul_start     = 1'b1;
                    st.pc_stall      = 1'b1;
                    st.if_id_stall   = 1'b1;
                    st.id_ex_stall   = 1'b1;
                    st.ex_mem_bubble = 1'b1;
                    cnt_d            = CW'(MUL_LAT - 1);
                    busy_d           = 1'b1;
                    state_d          = MUL;
                end else if (branch_flush) begin
                    st.if_id_flush  = 1'b1;
                    st.id_ex_bubble = 1'b1;
                end else if (load_use) begin
                    st.pc_stall     = 1'b1;
                    st.if_id_stall  = 1'b1;
                    st.id_ex_bubble = 1'b1;
                end
            end
            MUL: begin
                st.pc_stall      = 1'b1;
                st.if_id_stall   = 1'b1;
                st.id_ex_stall   = 1'b1;
                st.ex_mem_bubble = 1'b1;
                cnt_d            = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = MUL_DONE;
            end
            MUL_DONE: begin
                // Result is captured by EX/MEM this cycle unless the cache freezes it
                if (!dcache_stall) begin
                    state_d = RUN;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = RUN;
        endcase

        // A cache miss freezes everything but lets the multiplier keep counting
        if (dcache_stall) begin
            st              = '0;
            st.pc_stall     = 1'b1;
            st.if_id_stall  = 1'b1;
            st.id_ex_stall  = 1'b1;
            st.ex_mem_stall = 1'b1;
        end

        if (!rst_n) st = '0;

        stall_cnt_d = stall_cnt_q;
        if (st.pc_stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pc_stall      = st.pc_stall;
    assign if_id_stall   = st.if_id_stall;
    assign if_id_flush   = st.if_id_flush;
    assign id_ex_stall   = st.id_ex_stall;
    assign id_ex_bubble  = st.id_ex_bubble;
    assign ex_mem_stall  = st.ex_mem_stall;
    assign ex_mem_bubble = st.ex_mem_bubble;
    assign mul_start     = st.mul_start;
    assign mul_busy      = busy_q;
    assign stall_cycles  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MUL_LAT=4, 4-bit stall counter so saturation is reachable).
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       ID_rs1, ID_rs2, ID_EX_rd;
    logic             ID_use_rs1, ID_use_rs2, ID_EX_MemRead, ID_EX_is_mul;
    logic             dcache_stall, branch_flush;
    logic             pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble;
    logic             ex_mem_stall, ex_mem_bubble, mul_start, mul_busy;
    logic [CNT_W-1:0] stall_cycles;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MUL_LAT(4), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ID_rs1        (ID_rs1),
        .ID_rs2        (ID_rs2),
        .ID_use_rs1    (ID_use_rs1),
        .ID_use_rs2    (ID_use_rs2),
        .ID_EX_MemRead (ID_EX_MemRead),
        .ID_EX_rd      (ID_EX_rd),
        .ID_EX_is_mul  (ID_EX_is_mul),
        .dcache_stall  (dcache_stall),
        .branch_flush  (branch_flush),
        .pc_stall      (pc_stall),
        .if_id_stall   (if_id_stall),
        .if_id_flush   (if_id_flush),
        .id_ex_stall   (id_ex_stall),
        .id_ex_bubble  (id_ex_bubble),
        .ex_mem_stall  (ex_mem_stall),
        .ex_mem_bubble (ex_mem_bubble),
        .mul_start     (mul_start),
        .mul_busy      (mul_busy),
        .stall_cycles  (stall_cycles)
    );

    // Output vector order: {pc, ifid_stall, ifid_flush, idex_stall, idex_bubble,
    //                       exmem_stall, exmem_bubble, mul_start, mul_busy}
    wire [8:0] obs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
                      ex_mem_stall, ex_mem_bubble, mul_start, mul_busy};

    localparam logic [8:0] O_IDLE  = 9'b000000000;
    localparam logic [8:0] O_LU    = 9'b110010000;
    localparam logic [8:0] O_BR    = 9'b001010000;
    localparam logic [8:0] O_START = 9'b110100110;
    localparam logic [8:0] O_MUL   = 9'b110100101;
    localparam logic [8:0] O_DONE  = 9'b000000001;
    localparam logic [8:0] O_FRZB  = 9'b110101001;
    localparam logic [8:0] O_FRZ   = 9'b110101000;

    task automatic chk(input string tag, input logic [8:0] exp_o, input int exp_sc);
        n_cmp++;
        assert (obs === exp_o) else begin
            n_err++;
            $error("FAIL %s outputs: got %b expected %b", tag, obs, exp_o);
        end
        n_cmp++;
        assert (stall_cycles === CNT_W'(exp_sc)) else begin
            n_err++;
            $error("FAIL %s stall_cycles: got %0d expected %0d", tag, stall_cycles, exp_sc);
        end
    endtask

    task automatic idle_inputs();
        ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_use_rs1 = 1'b0; ID_use_rs2 = 1'b0;
        ID_EX_MemRead = 1'b0; ID_EX_rd = 5'd0; ID_EX_is_mul = 1'b0;
        dcache_stall = 1'b0; branch_flush = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with every event input active: outputs must stay low
        idle_inputs();
        rst_n = 1'b0;
        ID_EX_is_mul = 1'b1; ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd5;
        ID_rs1 = 5'd5; ID_use_rs1 = 1'b1; dcache_stall = 1'b1; branch_flush = 1'b1;
        next();
        @(negedge clk); chk("reset", O_IDLE, 0);
        next();
        idle_inputs(); rst_n = 1'b1;

        // 1: lw x5 in EX, add x6,x5,x1 in ID
        ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd5;
        ID_rs1 = 5'd5; ID_use_rs1 = 1'b1; ID_rs2 = 5'd1; ID_use_rs2 = 1'b1;
        @(negedge clk); chk("lu_rs1", O_LU, 0);
        next();
        ID_EX_MemRead = 1'b0; ID_EX_rd = 5'd6;
        @(negedge clk); chk("lu_release", O_IDLE, 1);
        next();

        // 2: load to x0; unused rs2 match; used rs2 match
        ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd0; ID_rs1 = 5'd0; ID_use_rs1 = 1'b1;
        @(negedge clk); chk("lu_x0", O_IDLE, 1);
        next();
        ID_EX_rd = 5'd5; ID_rs1 = 5'd3; ID_rs2 = 5'd5; ID_use_rs2 = 1'b0;
        @(negedge clk); chk("lu_rs2_unused", O_IDLE, 1);
        next();
        ID_use_rs2 = 1'b1;
        @(negedge clk); chk("lu_rs2", O_LU, 1);
        next();
        idle_inputs();

        // 5: branch flush beats a simultaneous load-use
        ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd7; ID_rs1 = 5'd7; ID_use_rs1 = 1'b1;
        branch_flush = 1'b1;
        @(negedge clk); chk("br_over_lu", O_BR, 2);
        next();
        idle_inputs();
        @(negedge clk); chk("br_after", O_IDLE, 2);
        next();

        // 3: plain multiply, 4 stall cycles then release
        ID_EX_is_mul = 1'b1;
        @(negedge clk); chk("mul_start", O_START, 2);
        next();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk($sformatf("mul_busy%0d", i), O_MUL, 3 + i);
            next();
        end
        @(negedge clk); chk("mul_done", O_DONE, 6);
        next();
        ID_EX_is_mul = 1'b0;
        @(negedge clk); chk("mul_after", O_IDLE, 6);
        next();

        // 4: cache miss from cnt=2 carries the FSM into MUL_DONE and holds it
        ID_EX_is_mul = 1'b1;
        @(negedge clk); chk("dc_start", O_START, 6);
        next();
        @(negedge clk); chk("dc_mul_cnt3", O_MUL, 7);
        next();
        dcache_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk($sformatf("dc_freeze%0d", i), O_FRZB, 8 + i);
            next();
        end
        dcache_stall = 1'b0;
        @(negedge clk); chk("dc_release", O_DONE, 11);
        next();
        ID_EX_is_mul = 1'b0;
        @(negedge clk); chk("dc_after", O_IDLE, 11);
        next();

        // Miss in RUN with a mul and a branch pending: pure freeze, no start
        ID_EX_is_mul = 1'b1; branch_flush = 1'b1; dcache_stall = 1'b1;
        @(negedge clk); chk("dc_run", O_FRZ, 11);
        next();
        idle_inputs();
        @(negedge clk); chk("dc_run_after", O_IDLE, 12);
        next();

        // 6: reset in the middle of a multiply
        ID_EX_is_mul = 1'b1;
        @(negedge clk); chk("rst_start", O_START, 12);
        next();
        @(negedge clk); chk("rst_mul", O_MUL, 13);
        next();
        rst_n = 1'b0;
        @(negedge clk); chk("rst_in_mul", O_DONE, 14);
        next();
        rst_n = 1'b1; ID_EX_is_mul = 1'b0;
        @(negedge clk); chk("rst_after", O_IDLE, 0);
        next();
        ID_EX_is_mul = 1'b1;
        @(negedge clk); chk("rst_run_restart", O_START, 0);
        next();
        repeat (4) next();
        ID_EX_is_mul = 1'b0;
        @(negedge clk); chk("rst_restart_done", O_IDLE, 4);
        next();

        // Counter saturation: 14 more stall cycles would wrap a 4-bit counter
        dcache_stall = 1'b1;
        repeat (14) next();
        @(negedge clk); chk("sat", O_FRZ, 15);
        next();
        @(negedge clk); chk("sat_hold", O_FRZ, 15);
        next();
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
